spike_rate_decoder: RTL and testbench

//   Output-side counterpart of the input spike generator. Counts spikes from the N output

---
 rtl/spike_rate_decoder_if.sv | 27 ++
 rtl/spike_rate_decoder.sv | 150 +++++++++++++++
 tb/tb_spike_rate_decoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_decoder_if.sv
// Handshake and result bundle between the readout controller and spike_rate_decoder.
// The master drives the window controls and spike vector. The slave (the decoder)
// returns the live or final counts, the winner and the status flags.
interface spike_rate_decoder_if #(
    parameter int N    = 8,
    parameter int CW   = 8,
    parameter int IDXW = 3
);
    logic              start_decode;
    logic              next_tu;
    logic [N-1:0]      spikes_in;
    logic [N*CW-1:0]   counts_packed;
    logic [IDXW-1:0]   winner;
    logic              tie;
    logic              result_valid;
    logic              busy;

    modport master (
        output start_decode, next_tu, spikes_in,
        input  counts_packed, winner, tie, result_valid, busy
    );

    modport slave (
        input  start_decode, next_tu, spikes_in,
        output counts_packed, winner, tie, result_valid, busy
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder. Counts output-neuron spikes over a window of WINDOW time units.
// It then scans the counters one neuron per clock to find the most active neuron.
// The lowest index wins ties. The tie flag reports that another neuron matched the maximum.
module spike_rate_decoder #(
    parameter int N      = 8,
    parameter int CW     = 8,
    parameter int WINDOW = 200,
    parameter int TW     = 8,
    parameter int IDXW   = 3
) (
    input logic                clk,
    input logic                rst,
    spike_rate_decoder_if.slave bus
);
    localparam logic [TW-1:0]   LAST_TU  = TW'(WINDOW - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, COUNT, ARGMAX, DONE} state_t;

    state_t          state, state_nxt;
    logic            clr;        // start_decode accepted: clear counters, open a window
    logic            do_count;   // accept this time unit's spikes
    logic            scan_en;    // compare one neuron this clock
    logic            scan_last;  // final neuron of the scan
    logic [CW-1:0]   cnt [N];
    logic [TW-1:0]   tu_cnt;
    logic [IDXW-1:0] idx;
    logic [CW-1:0]   max_val;
    logic [CW-1:0]   cur;
    logic [IDXW-1:0] winner;
    logic            tie;
    logic            result_valid;

    // Saturating increment: a counter that reaches all-ones stays there.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) return v;
        return v + CW'(1);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath strobes. start_decode outranks next_tu in every state.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        do_count  = 1'b0;
        scan_en   = 1'b0;
        scan_last = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start_decode) begin
                    clr       = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (bus.start_decode) begin
                    clr       = 1'b1;
                    state_nxt = COUNT;
                end else if (bus.next_tu) begin
                    do_count = 1'b1;
                    if (tu_cnt == LAST_TU) state_nxt = ARGMAX;
                end
            end
            ARGMAX: begin
                if (bus.start_decode) begin
                    clr       = 1'b1;
                    state_nxt = COUNT;
                end else begin
                    scan_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        scan_last = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-neuron spike counters. They are live in COUNT and frozen otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (do_count) begin
            for (int i = 0; i < N; i++)
                if (bus.spikes_in[i]) cnt[i] <= sat_inc(cnt[i]);
        end
    end

    // Time-unit counter for the open window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           tu_cnt <= '0;
        else if (clr)      tu_cnt <= '0;
        else if (do_count) tu_cnt <= tu_cnt + TW'(1);
    end

    // Scan index. It sits at 0 through COUNT, so every scan starts at neuron 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          idx <= '0;
        else if (clr)     idx <= '0;
        else if (scan_en) idx <= scan_last ? '0 : idx + IDXW'(1);
    end

    assign cur = cnt[idx];

    // Argmax scan. A strict greater-than keeps the lowest index on equal counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            winner  <= '0;
            tie     <= 1'b0;
        end else if (scan_en) begin
            if (idx == '0) begin
                max_val <= cur;
                winner  <= '0;
                tie     <= 1'b0;
            end else if (cur > max_val) begin
                max_val <= cur;
                winner  <= idx;
                tie     <= 1'b0;
            end else if (cur == max_val) begin
                tie <= 1'b1;
            end
        end
    end

    // Result-valid flag. Set as the last neuron is scanned; a new start drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            result_valid <= 1'b0;
        else if (clr)       result_valid <= 1'b0;
        else if (scan_last) result_valid <= 1'b1;
    end

    // Pack counters onto the result bus, neuron i at [i*CW +: CW].
    always_comb begin
        for (int i = 0; i < N; i++) bus.counts_packed[i*CW +: CW] = cnt[i];
    end

    assign bus.winner       = winner;
    assign bus.tie          = tie;
    assign bus.result_valid = result_valid;
    assign bus.busy         = (state == COUNT) || (state == ARGMAX);
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder. Two instances (CW=8 and CW=4) share one stimulus stream.
// Every cycle both are compared against a window-level reference model. The model keeps
// plain integer spike totals and computes the argmax and tie by a direct search.
module tb_spike_rate_decoder;
    localparam int N      = 8;
    localparam int WINDOW = 200;
    localparam int TW     = 8;
    localparam int IDXW   = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ntu;
    logic [N-1:0] spk;

    always #5 clk = ~clk;

    spike_rate_decoder_if #(.N(N), .CW(8), .IDXW(IDXW)) bus8 ();
    spike_rate_decoder_if #(.N(N), .CW(4), .IDXW(IDXW)) bus4 ();

    assign bus8.start_decode = start;
    assign bus8.next_tu      = ntu;
    assign bus8.spikes_in    = spk;
    assign bus4.start_decode = start;
    assign bus4.next_tu      = ntu;
    assign bus4.spikes_in    = spk;

    spike_rate_decoder #(.N(N), .CW(8), .WINDOW(WINDOW), .TW(TW), .IDXW(IDXW)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );
    spike_rate_decoder #(.N(N), .CW(4), .WINDOW(WINDOW), .TW(TW), .IDXW(IDXW)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: window-level view
    int m8[N];
    int m4[N];
    int m_tu;
    bit m_counting;
    bit m_scanning;
    int m_scan_left;
    bit m_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic void find_max(input int c[N], output int w, output bit t);
        int best;
        int hits;
        best = -1;
        w    = 0;
        for (int i = 0; i < N; i++)
            if (c[i] > best) begin best = c[i]; w = i; end
        hits = 0;
        for (int i = 0; i < N; i++) if (c[i] == best) hits++;
        t = (hits > 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m8[i] = 0; m4[i] = 0; end
        m_tu = 0; m_counting = 0; m_scanning = 0; m_scan_left = 0; m_valid = 0;
    endtask

    // Apply one clock edge worth of input to the model.
    task automatic model_edge();
        if (start) begin
            for (int i = 0; i < N; i++) begin m8[i] = 0; m4[i] = 0; end
            m_tu = 0; m_counting = 1; m_scanning = 0; m_valid = 0;
        end else if (m_counting && ntu) begin
            for (int i = 0; i < N; i++)
                if (spk[i]) begin m8[i] = sat(m8[i], 255); m4[i] = sat(m4[i], 15); end
            m_tu++;
            if (m_tu == WINDOW) begin
                m_counting = 0; m_scanning = 1; m_scan_left = N;
            end
        end else if (m_scanning) begin
            m_scan_left--;
            if (m_scan_left == 0) begin m_scanning = 0; m_valid = 1; end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e8;
        logic [63:0] e4;
        int w;
        bit t;
        e8 = '0;
        e4 = '0;
        for (int i = 0; i < N; i++) begin
            e8[i*8 +: 8] = 8'(m8[i]);
            e4[i*4 +: 4] = 4'(m4[i]);
        end
        check_eq("cnt8",   64'(bus8.counts_packed), e8);
        check_eq("cnt4",   64'(bus4.counts_packed), e4);
        check_eq("busy8",  64'(bus8.busy), 64'(m_counting || m_scanning));
        check_eq("busy4",  64'(bus4.busy), 64'(m_counting || m_scanning));
        check_eq("valid8", 64'(bus8.result_valid), 64'(m_valid));
        check_eq("valid4", 64'(bus4.result_valid), 64'(m_valid));
        if (m_valid) begin
            find_max(m8, w, t);
            check_eq("win8", 64'(bus8.winner), 64'(w));
            check_eq("tie8", 64'(bus8.tie), 64'(t));
            find_max(m4, w, t);
            check_eq("win4", 64'(bus4.winner), 64'(w));
            check_eq("tie4", 64'(bus4.tie), 64'(t));
        end
    endtask

    task automatic cycle(input bit s, input bit n, input logic [N-1:0] sp);
        start = s;
        ntu   = n;
        spk   = sp;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic logic [N-1:0] pattern(input int mode, input int tu);
        logic [N-1:0] sp;
        sp = '0;
        case (mode)
            0: begin sp = (tu % 4 == 0) ? '1 : '0; sp[3] = 1'b1; end
            1: for (int i = 0; i < N; i++) sp[i] = (tu < ((i == 2 || i == 5) ? 10 : 3));
            2: sp[0] = 1'b1;
            3: sp = '0;
            5: sp = '1;
            default: sp = N'($urandom) & N'($urandom);
        endcase
        return sp;
    endfunction

    // Full window: start, WINDOW time units with random idle gaps, then the scan and a DONE tail.
    task automatic run_window(input int mode);
        cycle(1'b1, 1'b0, N'($urandom));
        for (int tu = 0; tu < WINDOW; tu++) begin
            if ($urandom_range(3) == 0) cycle(1'b0, 1'b0, N'($urandom));
            cycle(1'b0, 1'b1, pattern(mode, tu));
        end
        for (int k = 0; k < N + 3; k++) cycle(1'b0, 1'($urandom_range(1)), N'($urandom));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ntu   = 1'b0;
        spk   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
        check_eq("rst_win", 64'(bus8.winner), 64'd0);
        check_eq("rst_tie", 64'(bus8.tie), 64'd0);

        // Neuron 3 fires every TU, the others every 4th TU.
        run_window(0);
        check_eq("t2_c3", 64'(bus8.counts_packed[3*8 +: 8]), 64'd200);
        check_eq("t2_c0", 64'(bus8.counts_packed[0 +: 8]), 64'd50);
        check_eq("t2_win", 64'(bus8.winner), 64'd3);
        check_eq("t2_tie", 64'(bus8.tie), 64'd0);
        check_eq("t2_vld", 64'(bus8.result_valid), 64'd1);

        // Asynchronous reset in the middle of a counting window.
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, '1);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check_eq("t1_win", 64'(bus8.winner), 64'd0);
        check_eq("t1_tie", 64'(bus8.tie), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '1);

        // Two neurons tie at 10: the lower index wins and tie is set.
        run_window(1);
        check_eq("t3_win", 64'(bus8.winner), 64'd2);
        check_eq("t3_tie", 64'(bus8.tie), 64'd1);

        // Neuron 0 fires on every TU: the 4-bit counter saturates.
        run_window(2);
        check_eq("t4_c4", 64'(bus4.counts_packed[0 +: 4]), 64'd15);
        check_eq("t4_c8", 64'(bus8.counts_packed[0 +: 8]), 64'd200);

        // Silent window.
        run_window(3);
        check_eq("t6_win", 64'(bus8.winner), 64'd0);
        check_eq("t6_tie", 64'(bus8.tie), 64'd1);
        check_eq("t6_vld", 64'(bus8.result_valid), 64'd1);

        // Restart mid-window, then start and next_tu together with all spikes set.
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, N'($urandom));
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, '1);
        check_eq("t5_cnt", 64'(bus8.counts_packed), 64'd0);
        for (int i = 0; i < WINDOW - 1; i++) cycle(1'b0, 1'b1, N'($urandom));
        for (int i = 0; i < N + 3; i++) cycle(1'b0, 1'b0, '0);
        check_eq("t5_early", 64'(bus8.result_valid), 64'd0);
        cycle(1'b0, 1'b1, '1);
        for (int i = 0; i < N - 1; i++) cycle(1'b0, 1'b0, '0);
        check_eq("t5_lat_lo", 64'(bus8.result_valid), 64'd0);
        cycle(1'b0, 1'b0, '0);
        check_eq("t5_lat_hi", 64'(bus8.result_valid), 64'd1);

        // Abort during the argmax scan.
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < WINDOW; i++) cycle(1'b0, 1'b1, N'($urandom));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check_eq("abort_vld", 64'(bus8.result_valid), 64'd0);
        check_eq("abort_busy", 64'(bus8.busy), 64'd1);

        // All neurons saturate or tie, followed by random windows.
        run_window(5);
        for (int r = 0; r < 3; r++) run_window(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
